// File: rtl/uart_echo_bridge_if.sv
// Word-stream bundle between the UART RX/TX modules and the echo bridge.
interface uart_echo_bridge_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Bridge side: consumes RX strobes, offers words to TX.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );

  // Serial-module side: produces RX strobes, accepts TX words.
  modport master (
    output rx_data,
    output rx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );
endinterface

// File: rtl/uart_echo_bridge.sv
// UART echo bridge: buffers received words in a FIFO towards TX and decodes
// an in-band escape protocol for line mode, echo enable and overflow clear.
module uart_echo_bridge #(
  parameter int unsigned            DATA_W   = 8,
  parameter int unsigned            DEPTH    = 16,
  parameter int unsigned            MODE_W   = 4,
  parameter logic [MODE_W-1:0]      MODE_RST = MODE_W'(1),
  parameter logic [DATA_W-1:0]      ESC      = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_echo_bridge_if.slave        bus,
  output logic [MODE_W-1:0]        mode,
  output logic                     echo_en,
  output logic                     esc_pending,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [DATA_W-1:0] CMD_ECHO_OFF = DATA_W'(8'hE0);
  localparam logic [DATA_W-1:0] CMD_ECHO_ON  = DATA_W'(8'hE1);
  localparam logic [DATA_W-1:0] CMD_OVF_CLR  = DATA_W'(8'hE2);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              echo_en_q, echo_en_d;
  logic              esc_q, esc_d;
  logic              overflow_q, overflow_d;

  logic              tx_valid_c;
  logic              full_c;
  logic              pop_c;
  logic              push_req_c;
  logic              push_c;
  logic              drop_c;
  logic              ovf_clr_c;

  // FIFO handshake qualifiers; a pop in the same cycle frees room for a push when full.
  always_comb begin
    tx_valid_c = (count_q != '0);
    full_c     = (count_q == CNT_W'(DEPTH));
    pop_c      = tx_valid_c & bus.tx_ready;
    push_req_c = bus.rx_valid & echo_en_q;
    push_c     = push_req_c & (~full_c | pop_c);
    drop_c     = push_req_c & full_c & ~pop_c;
  end

  // Command decoder and FIFO next-state.
  always_comb begin
    mode_d     = mode_q;
    echo_en_d  = echo_en_q;
    esc_d      = esc_q;
    ovf_clr_c  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;

    if (bus.rx_valid) begin
      if (bus.rx_data == ESC) begin
        esc_d = 1'b1;
      end else begin
        esc_d = 1'b0;
        if (esc_q) begin
          if (bus.rx_data[DATA_W-1 -: 4] == 4'hF) begin
            mode_d = bus.rx_data[MODE_W-1:0];
          end else if (bus.rx_data == CMD_ECHO_OFF) begin
            echo_en_d = 1'b0;
          end else if (bus.rx_data == CMD_ECHO_ON) begin
            echo_en_d = 1'b1;
          end else if (bus.rx_data == CMD_OVF_CLR) begin
            ovf_clr_c = 1'b1;
          end
        end
      end
    end

    // A drop in the same cycle as a clear command wins, so no loss goes unreported.
    overflow_d = (overflow_q & ~ovf_clr_c) | drop_c;

    if (push_c) begin
      mem_d[wr_ptr_q] = bus.rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and pointer state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_RST;
      echo_en_q  <= 1'b1;
      esc_q      <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mode_q     <= mode_d;
      echo_en_q  <= echo_en_d;
      esc_q      <= esc_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are meaningless once pointers are reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.tx_data  = mem_q[rd_ptr_q];
  assign bus.tx_valid = tx_valid_c;
  assign mode         = mode_q;
  assign echo_en      = echo_en_q;
  assign esc_pending  = esc_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule
